// File: rtl/wb_initiator_pkg.sv
// Shared types and constants for the Wishbone classic-cycle initiator.
package wb_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEFAULT_AW = 32;
    localparam int DEFAULT_DW = 32;

    // Read data returned on an aborted cycle; sliced down to DW bits by the user.
    localparam logic [63:0] TIMEOUT_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/wb_initiator_timer.sv
// Clearable, saturating wait-for-ack counter; reached flags the edge on which
// the count would hit TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 disables it entirely.
module wb_initiator_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic reached
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable && count != LIMIT) begin
            count <= count + TW'(1);
        end
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_never
            assign reached = 1'b0;
        end else begin : g_limit
            assign reached = enable && (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/wb_initiator.sv
// Single-beat Wishbone classic initiator with command/response handshakes.
// Define WB_INITIATOR_STATS_EN to add saturating transaction/timeout counters.
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int AW             = DEFAULT_AW,
    parameter int DW             = DEFAULT_DW,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic [DW-1:0]   cmd_dat_i,
    input  logic [DW/8-1:0] cmd_sel_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_dat_o,
    output logic            rsp_timeout_o,
`ifdef WB_INITIATOR_STATS_EN
    output logic [15:0]     txn_count_o,
    output logic [15:0]     timeout_count_o,
`endif
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i
);

    state_t state;
    logic   expired;

    // Timer is held clear while idle so every bus cycle starts counting from zero.
    wb_initiator_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n),
        .clear   (state == IDLE),
        .enable  (state == BUS && !wbm_ack_i),
        .reached (expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state         <= IDLE;
            cmd_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_dat_o     <= '0;
            rsp_timeout_o <= 1'b0;
            wbm_cyc_o     <= 1'b0;
            wbm_stb_o     <= 1'b0;
            wbm_we_o      <= 1'b0;
            wbm_sel_o     <= '0;
            wbm_adr_o     <= '0;
            wbm_dat_o     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        wbm_we_o    <= cmd_we_i;
                        wbm_adr_o   <= cmd_adr_i;
                        wbm_dat_o   <= cmd_dat_i;
                        wbm_sel_o   <= cmd_sel_i;
                        wbm_cyc_o   <= 1'b1;
                        wbm_stb_o   <= 1'b1;
                        cmd_ready_o <= 1'b0;
                        state       <= BUS;
                    end
                end
                BUS: begin
                    // Ack is checked first so it wins over a simultaneous timeout.
                    if (wbm_ack_i) begin
                        wbm_cyc_o     <= 1'b0;
                        wbm_stb_o     <= 1'b0;
                        rsp_dat_o     <= wbm_we_o ? '0 : wbm_dat_i;
                        rsp_timeout_o <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        state         <= RESP;
                    end else if (expired) begin
                        wbm_cyc_o     <= 1'b0;
                        wbm_stb_o     <= 1'b0;
                        rsp_dat_o     <= TIMEOUT_DATA[DW-1:0];
                        rsp_timeout_o <= 1'b1;
                        rsp_valid_o   <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_INITIATOR_STATS_EN
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            txn_count_o     <= '0;
            timeout_count_o <= '0;
        end else if (state == RESP && rsp_ready_i) begin
            if (txn_count_o != 16'hFFFF) begin
                txn_count_o <= txn_count_o + 16'd1;
            end
            if (rsp_timeout_o && timeout_count_o != 16'hFFFF) begin
                timeout_count_o <= timeout_count_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator: directed scenarios plus randomized
// transactions checked against an arithmetic model of ack/timeout outcomes.
module tb_wb_initiator;

    localparam int T  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_valid, cmd_we;
    logic [AW-1:0]   cmd_adr;
    logic [DW-1:0]   cmd_dat;
    logic [3:0]      cmd_sel;
    logic            rsp_ready;
    logic [DW-1:0]   wbm_dat;
    logic            wbm_ack;
    logic            cmd_ready_o, rsp_valid_o, rsp_timeout_o;
    logic [DW-1:0]   rsp_dat_o;
    logic            wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]      wbm_sel_o;
    logic [AW-1:0]   wbm_adr_o;
    logic [DW-1:0]   wbm_dat_o;
`ifdef WB_INITIATOR_STATS_EN
    logic [15:0]     txn_count_o, timeout_count_o;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int txn_m       = 0;
    int to_m        = 0;

    always #5 clk = ~clk;

    wb_initiator #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(T)) dut (
        .wb_clk_i        (clk),
        .wb_rst_n        (rst_n),
        .cmd_valid_i     (cmd_valid),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_we_i        (cmd_we),
        .cmd_adr_i       (cmd_adr),
        .cmd_dat_i       (cmd_dat),
        .cmd_sel_i       (cmd_sel),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready),
        .rsp_dat_o       (rsp_dat_o),
        .rsp_timeout_o   (rsp_timeout_o),
`ifdef WB_INITIATOR_STATS_EN
        .txn_count_o     (txn_count_o),
        .timeout_count_o (timeout_count_o),
`endif
        .wbm_cyc_o       (wbm_cyc_o),
        .wbm_stb_o       (wbm_stb_o),
        .wbm_we_o        (wbm_we_o),
        .wbm_sel_o       (wbm_sel_o),
        .wbm_adr_o       (wbm_adr_o),
        .wbm_dat_o       (wbm_dat_o),
        .wbm_dat_i       (wbm_dat),
        .wbm_ack_i       (wbm_ack)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the slave withholds ack for ack_wait stb cycles; the bus is
    // aborted once T stb cycles have passed without ack.
    function automatic logic exp_timeout(input int ack_wait);
        return (T != 0) && (ack_wait >= T);
    endfunction

    function automatic int exp_stb(input int ack_wait);
        return exp_timeout(ack_wait) ? T : ack_wait + 1;
    endfunction

    function automatic logic [31:0] exp_rdat(input logic we, input int ack_wait, input logic [31:0] ack_dat);
        if (exp_timeout(ack_wait)) return 32'hFFFF_FFFF;
        return we ? 32'h0 : ack_dat;
    endfunction

    // Drives one command, plays the slave, holds the response for `hold` cycles.
    task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int ack_wait, input logic [31:0] ack_dat,
                          input int hold, input logic late_ack,
                          output logic got, output logic [31:0] rdat, output logic rto,
                          output int stb_n, output int lat, output logic bus_ok,
                          output logic hold_ok, output logic idle_ok);
        got = 0; rdat = '0; rto = 0; stb_n = 0; lat = 0; bus_ok = 1; hold_ok = 1; idle_ok = 0;
        cmd_valid = 1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        rsp_ready = (hold == 0);
        step();
        lat = 1;
        cmd_valid = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (rsp_valid_o) begin
                got = 1;
            end else begin
                if (wbm_stb_o) begin
                    stb_n++;
                    if (!wbm_cyc_o || wbm_we_o !== we || wbm_adr_o !== adr ||
                        wbm_dat_o !== dat || wbm_sel_o !== sel || cmd_ready_o !== 1'b0)
                        bus_ok = 0;
                    wbm_ack = (stb_n == ack_wait + 1);
                    wbm_dat = ack_dat;
                end else begin
                    bus_ok = 0;
                end
                step();
                lat++;
                wbm_ack = 0;
                wbm_dat = $urandom;
            end
        end
        txn_m++;
        if (exp_timeout(ack_wait)) to_m++;
        if (got) begin
            rdat = rsp_dat_o;
            rto  = rsp_timeout_o;
            if (wbm_cyc_o || wbm_stb_o) bus_ok = 0;
            for (int k = 0; k < hold; k++) begin
                cmd_valid = 1;
                cmd_adr   = $urandom;
                wbm_ack   = late_ack;
                wbm_dat   = $urandom;
                step();
                if (rsp_valid_o !== 1'b1 || rsp_dat_o !== rdat || rsp_timeout_o !== rto ||
                    cmd_ready_o !== 1'b0 || wbm_stb_o !== 1'b0)
                    hold_ok = 0;
            end
            cmd_valid = 0;
            wbm_ack   = 0;
            rsp_ready = 1;
            step();
            idle_ok = (rsp_valid_o === 1'b0) && (cmd_ready_o === 1'b1) && (wbm_stb_o === 1'b0);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; cmd_valid = 0; cmd_we = 0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 0; wbm_ack = 0; wbm_dat = '0;
        repeat (3) step();
        rst_n = 1;
        step();
        vectors++;
        if (cmd_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready_o);
        end
        vectors++;
        if ({rsp_valid_o, rsp_dat_o, rsp_timeout_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
             wbm_sel_o, wbm_adr_o, wbm_dat_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got cyc=%b stb=%b rsp_valid=%b adr=%h exp all zero",
                     wbm_cyc_o, wbm_stb_o, rsp_valid_o, wbm_adr_o);
        end
        txn_m = 0; to_m = 0;
    endtask

    task automatic test_write();
        logic got, rto, bok, hok, iok; logic [31:0] rdat; int stb_n, lat;
        do_txn(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 2, 32'h1111_2222, 4, 1'b0,
               got, rdat, rto, stb_n, lat, bok, hok, iok);
        vectors++;
        if (!got || rdat !== 32'h0 || rto !== 1'b0) begin
            miscompares++;
            $display("FAIL write_rsp got=%b dat=%h to=%b exp got=1 dat=0 to=0", got, rdat, rto);
        end
        vectors++;
        if (stb_n != 3 || lat != 4) begin
            miscompares++;
            $display("FAIL write_timing stb=%0d lat=%0d exp stb=3 lat=4", stb_n, lat);
        end
        vectors++;
        if (!(bok && hok && iok)) begin
            miscompares++;
            $display("FAIL write_hold bus=%b hold=%b idle=%b exp 1 1 1", bok, hok, iok);
        end
    endtask

    task automatic test_read();
        logic got, rto, bok, hok, iok; logic [31:0] rdat; int stb_n, lat;
        do_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 32'hDEAD_0001, 0, 1'b0,
               got, rdat, rto, stb_n, lat, bok, hok, iok);
        vectors++;
        if (rdat !== 32'hDEAD_0001 || rto !== 1'b0) begin
            miscompares++;
            $display("FAIL read_rsp dat=%h to=%b exp dat=dead0001 to=0", rdat, rto);
        end
        vectors++;
        if (lat != 2 || !iok) begin
            miscompares++;
            $display("FAIL read_latency lat=%0d idle=%b exp lat=2 idle=1", lat, iok);
        end
    endtask

    task automatic test_timeout();
        logic got, rto, bok, hok, iok; logic [31:0] rdat; int stb_n, lat;
        do_txn(1'b0, 32'h3000_0008, 32'h0, 4'h3, 1000, 32'h0, 3, 1'b1,
               got, rdat, rto, stb_n, lat, bok, hok, iok);
        vectors++;
        if (rdat !== 32'hFFFF_FFFF || rto !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_rsp dat=%h to=%b exp dat=ffffffff to=1", rdat, rto);
        end
        vectors++;
        if (stb_n != T || lat != T + 1) begin
            miscompares++;
            $display("FAIL timeout_timing stb=%0d lat=%0d exp stb=%0d lat=%0d", stb_n, lat, T, T + 1);
        end
        vectors++;
        if (!(bok && hok && iok)) begin
            miscompares++;
            $display("FAIL timeout_late_ack bus=%b hold=%b idle=%b exp 1 1 1", bok, hok, iok);
        end
    endtask

    task automatic test_ack_wins();
        logic got, rto, bok, hok, iok; logic [31:0] rdat; int stb_n, lat;
        do_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, T - 1, 32'h0BAD_CAFE, 0, 1'b0,
               got, rdat, rto, stb_n, lat, bok, hok, iok);
        vectors++;
        if (rto !== 1'b0 || rdat !== 32'h0BAD_CAFE || stb_n != T) begin
            miscompares++;
            $display("FAIL ack_wins to=%b dat=%h stb=%0d exp to=0 dat=0badcafe stb=%0d", rto, rdat, stb_n, T);
        end
    endtask

    task automatic test_backpressure();
        logic got, rto, bok, hok, iok; logic [31:0] rdat; int stb_n, lat;
        do_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1, 32'h1234_5678, 10, 1'b0,
               got, rdat, rto, stb_n, lat, bok, hok, iok);
        vectors++;
        if (!hok || !iok || rdat !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL backpressure hold=%b idle=%b dat=%h exp 1 1 12345678", hok, iok, rdat);
        end
    endtask

    task automatic test_back_to_back();
        logic got, rto, bok, hok, iok; logic [31:0] rdat; int stb_n, lat;
        time t0, t1;
        t0 = $time;
        do_txn(1'b1, 32'h3000_0030, 32'h5555_AAAA, 4'h1, 0, 32'h0, 0, 1'b0,
               got, rdat, rto, stb_n, lat, bok, hok, iok);
        t1 = $time;
        do_txn(1'b0, 32'h3000_0034, 32'h0, 4'hF, 0, 32'h7777_0000, 0, 1'b0,
               got, rdat, rto, stb_n, lat, bok, hok, iok);
        vectors++;
        if ((t1 - t0) != 30 || rdat !== 32'h7777_0000 || !bok) begin
            miscompares++;
            $display("FAIL back_to_back spacing=%0t dat=%h bus=%b exp 30 77770000 1", t1 - t0, rdat, bok);
        end
    endtask

    task automatic test_reset_mid_bus();
        logic got, rto, bok, hok, iok; logic [31:0] rdat; int stb_n, lat;
        cmd_valid = 1; cmd_we = 1; cmd_adr = 32'h3000_0040; cmd_dat = 32'hFEED_BEEF; cmd_sel = 4'hF;
        rsp_ready = 0;
        step();
        cmd_valid = 0;
        vectors++;
        if (wbm_stb_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_bus_stb got=%b exp=1", wbm_stb_o);
        end
        rst_n = 0;
        step();
        rst_n = 1;
        txn_m = 0; to_m = 0;
        vectors++;
        if (cmd_ready_o !== 1'b1 ||
            {rsp_valid_o, rsp_dat_o, rsp_timeout_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
             wbm_sel_o, wbm_adr_o, wbm_dat_o} !== '0) begin
            miscompares++;
            $display("FAIL mid_bus_reset ready=%b cyc=%b stb=%b adr=%h exp ready=1 rest 0",
                     cmd_ready_o, wbm_cyc_o, wbm_stb_o, wbm_adr_o);
        end
        do_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1, 32'hC0DE_0042, 1, 1'b0,
               got, rdat, rto, stb_n, lat, bok, hok, iok);
        vectors++;
        if (rdat !== 32'hC0DE_0042 || rto !== 1'b0 || !iok) begin
            miscompares++;
            $display("FAIL after_reset_read dat=%h to=%b idle=%b exp c0de0042 0 1", rdat, rto, iok);
        end
    endtask

    task automatic test_random();
        logic got, rto, bok, hok, iok; logic [31:0] rdat; int stb_n, lat;
        logic we; logic [31:0] adr, dat, adat; logic [3:0] sel; int aw, hold;
        for (int n = 0; n < 30; n++) begin
            we = 1'($urandom); adr = $urandom; dat = $urandom; sel = 4'($urandom);
            adat = $urandom; aw = $urandom_range(0, T + 2); hold = $urandom_range(0, 3);
            do_txn(we, adr, dat, sel, aw, adat, hold, 1'($urandom),
                   got, rdat, rto, stb_n, lat, bok, hok, iok);
            vectors++;
            if (!got || rdat !== exp_rdat(we, aw, adat) || rto !== exp_timeout(aw) ||
                stb_n != exp_stb(aw) || lat != exp_stb(aw) + 1 || !bok || !hok || !iok) begin
                miscompares++;
                $display("FAIL random_%0d we=%b wait=%0d dat=%h to=%b stb=%0d lat=%0d ok=%b%b%b exp dat=%h to=%b stb=%0d",
                         n, we, aw, rdat, rto, stb_n, lat, bok, hok, iok,
                         exp_rdat(we, aw, adat), exp_timeout(aw), exp_stb(aw));
            end
        end
    endtask

`ifdef WB_INITIATOR_STATS_EN
    task automatic test_stats();
        logic got, rto, bok, hok, iok; logic [31:0] rdat; int stb_n, lat;
        int waits[5] = '{0, 1000, 2, 1000, 1};
        rst_n = 0;
        step();
        rst_n = 1;
        txn_m = 0; to_m = 0;
        for (int n = 0; n < 5; n++)
            do_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, waits[n], 32'h0, 0, 1'b0,
                   got, rdat, rto, stb_n, lat, bok, hok, iok);
        vectors++;
        if (txn_count_o !== 16'(txn_m) || timeout_count_o !== 16'(to_m) || txn_m != 5 || to_m != 2) begin
            miscompares++;
            $display("FAIL stats txn=%0d to=%0d exp txn=%0d to=%0d", txn_count_o, timeout_count_o, txn_m, to_m);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_ack_wins();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_bus();
        test_random();
`ifdef WB_INITIATOR_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
